// File: rtl/ral_bus_master.sv
// ral_bus_master: valid/ready initiator for the 3-bit address / 8-bit data
// register-bank bus. Reads return data one cycle after the bank samples the
// address; writes keep the bank busy for WR_BUSY_CYC cycles before it commits.
// Build option RAL_MASTER_RDBACK_EN: after each write's commit window, read
// the same register back and report that value, flagging any mismatch.
module ral_bus_master #(
  parameter int         WR_BUSY_CYC = 4,
  parameter logic [2:0] IDLE_ADDR   = 3'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [2:0] req_addr_i,
  input  logic [7:0] req_data_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_err_o,
  output logic [2:0] add_o,
  output logic [7:0] dt_o,
  output logic       r_w_o,
  input  logic [7:0] dt_i
);

  localparam int CNT_W = (WR_BUSY_CYC > 1) ? $clog2(WR_BUSY_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_CAP   = 3'd2,
    WR_ISSUE = 3'd3,
    WR_WAIT  = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       add_nxt;
  logic [7:0]       dt_nxt;
  logic             rw_nxt;
  logic [7:0]       rsp_data_nxt;
  logic             rsp_err_nxt;
  logic [7:0]       data_q, data_nxt;
`ifdef RAL_MASTER_RDBACK_EN
  logic [2:0]       addr_q, addr_nxt;
  logic             rdbk_q, rdbk_nxt;
`endif

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);

  // Next state, bus drive and response values; everything holds unless a state changes it.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    add_nxt      = add_o;
    dt_nxt       = dt_o;
    rw_nxt       = r_w_o;
    rsp_data_nxt = rsp_data_o;
    rsp_err_nxt  = rsp_err_o;
    data_nxt     = data_q;
`ifdef RAL_MASTER_RDBACK_EN
    addr_nxt     = addr_q;
    rdbk_nxt     = rdbk_q;
`endif
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          data_nxt = req_data_i;
`ifdef RAL_MASTER_RDBACK_EN
          addr_nxt = req_addr_i;
          rdbk_nxt = 1'b0;
`endif
          if (!req_write_i) begin
            add_nxt   = req_addr_i;
            rw_nxt    = 1'b0;
            state_nxt = RD_ISSUE;
          end else if (req_addr_i != 3'd0) begin
            add_nxt   = req_addr_i;
            dt_nxt    = req_data_i;
            rw_nxt    = 1'b1;
            state_nxt = WR_ISSUE;
          end else begin
            // Register 0 is read-only: refuse without touching the bus.
            rsp_data_nxt = 8'd0;
            rsp_err_nxt  = 1'b1;
            state_nxt    = RESP;
          end
        end
      end
      RD_ISSUE: begin
        // The bank has sampled the address; park the bus so it sees exactly one read.
        add_nxt   = IDLE_ADDR;
        rw_nxt    = 1'b0;
        state_nxt = RD_CAP;
      end
      RD_CAP: begin
        rsp_data_nxt = dt_i;
`ifdef RAL_MASTER_RDBACK_EN
        rsp_err_nxt  = rdbk_q && (dt_i != data_q);
`else
        rsp_err_nxt  = 1'b0;
`endif
        add_nxt      = IDLE_ADDR;
        rw_nxt       = 1'b0;
        state_nxt    = RESP;
      end
      WR_ISSUE: begin
        add_nxt   = IDLE_ADDR;
        rw_nxt    = 1'b0;
        cnt_nxt   = CNT_W'(WR_BUSY_CYC - 1);
        state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        if (cnt == '0) begin
`ifdef RAL_MASTER_RDBACK_EN
          // Commit edge: the bank is free again, so the read-back can go out now.
          add_nxt   = addr_q;
          rw_nxt    = 1'b0;
          rdbk_nxt  = 1'b1;
          state_nxt = RD_ISSUE;
`else
          rsp_data_nxt = data_q;
          rsp_err_nxt  = 1'b0;
          state_nxt    = RESP;
`endif
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, registered bus outputs and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      add_o      <= IDLE_ADDR;
      dt_o       <= 8'd0;
      r_w_o      <= 1'b0;
      rsp_data_o <= 8'd0;
      rsp_err_o  <= 1'b0;
`ifdef RAL_MASTER_RDBACK_EN
      rdbk_q     <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      add_o      <= add_nxt;
      dt_o       <= dt_nxt;
      r_w_o      <= rw_nxt;
      rsp_data_o <= rsp_data_nxt;
      rsp_err_o  <= rsp_err_nxt;
`ifdef RAL_MASTER_RDBACK_EN
      rdbk_q     <= rdbk_nxt;
`endif
    end
  end

  // Latched request payload; only meaningful once a request is in flight.
  always_ff @(posedge clk) begin
    data_q <= data_nxt;
`ifdef RAL_MASTER_RDBACK_EN
    addr_q <= addr_nxt;
`endif
  end

endmodule

// File: tb/tb_ral_bus_master.sv
// Testbench for ral_bus_master: a behavioural register bank answers the bus,
// and a request-level model predicts each response's data, error and latency.
`timescale 1ns/1ps
module tb_ral_bus_master;

  localparam int         WR_BUSY_CYC = 4;
  localparam logic [2:0] IDLE_ADDR   = 3'd1;
`ifdef RAL_MASTER_RDBACK_EN
  localparam int WR_LAT = WR_BUSY_CYC + 3;
`else
  localparam int WR_LAT = WR_BUSY_CYC + 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [2:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_data;
  logic [2:0] add;
  logic [7:0] dt_out, dt_in;
  logic       r_w;

  ral_bus_master #(.WR_BUSY_CYC(WR_BUSY_CYC), .IDLE_ADDR(IDLE_ADDR)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .add_o(add), .dt_o(dt_out), .r_w_o(r_w), .dt_i(dt_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register bank: reg 0 is a read-only sequence that advances on each read of it.
  logic [7:0] bank_mem [8];
  logic [7:0] bank_rnd;
  int         bank_busy;
  logic [2:0] bank_wa;
  logic [7:0] bank_wd;
  int         bus_wr_cnt = 0, bus_rd0_cnt = 0, bus_viol = 0;
  logic [2:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) bank_mem[i] <= 8'd0;
      bank_rnd  <= 8'h5A;
      bank_busy <= 0;
      dt_in     <= 8'd0;
    end else if (bank_busy > 0) begin
      if (r_w || add != IDLE_ADDR) bus_viol <= bus_viol + 1;
      if (bank_busy == 1 && bank_wa != 3'd0) bank_mem[bank_wa] <= bank_wd;
      bank_busy <= bank_busy - 1;
    end else if (r_w) begin
      bank_busy    <= WR_BUSY_CYC;
      bank_wa      <= add;
      bank_wd      <= dt_out;
      bus_wr_cnt   <= bus_wr_cnt + 1;
      last_wr_addr <= add;
      last_wr_data <= dt_out;
    end else if (add == 3'd0) begin
      dt_in       <= bank_rnd;
      bank_rnd    <= bank_rnd + 8'd29;
      bus_rd0_cnt <= bus_rd0_cnt + 1;
    end else begin
      dt_in <= bank_mem[add];
    end
  end

  int rsp_cnt = 0;
  always @(negedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Request-level reference model.
  logic [7:0] ref_mem [8];
  int ref_rd0 = 0, ref_rd0_total = 0, n_rsp_exp = 0, last_rsp_cyc = 0;

  task automatic model(input bit w, input logic [2:0] a, input logic [7:0] d,
                       output logic [7:0] ed, output bit ee, output int el, output int ewr);
    ewr = 0;
    ee  = 1'b0;
    if (!w) begin
      el = 2;
      if (a == 3'd0) begin
        ed = 8'(32'h5A + 29 * ref_rd0);
        ref_rd0++;
        ref_rd0_total++;
      end else begin
        ed = ref_mem[a];
      end
    end else if (a == 3'd0) begin
      el = 0;   // refused write responds in the cycle right after the accept edge
      ee = 1'b1;
      ed = 8'd0;
    end else begin
      el = WR_LAT;
      ed = d;
      ewr = 1;
      ref_mem[a] = d;
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'd0;
    ref_rd0 = 0;
  endtask

  task automatic wait_accept(output bit acc);
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin acc = 1'b1; break; end
    end
    if (acc) begin @(posedge clk); #1; end
  endtask

  task automatic do_req(input bit w, input logic [2:0] a, input logic [7:0] d, input bit b2b);
    logic [7:0] ed;
    bit ee, acc, rdy_seen;
    int el, ewr, wr0, lat;
    model(w, a, d, ed, ee, el, ewr);
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
    wr0 = bus_wr_cnt;
    wait_accept(acc);
    chk("accept", 32'(acc), 32'd1);
    if (!acc) begin req_valid = 1'b0; return; end
    n_rsp_exp++;
    if (b2b) chk("b2b_gap", 32'(cyc - last_rsp_cyc), 32'd2);
    // Keep valid high with junk payload: the master must ignore it while busy.
    req_write = 1'($urandom); req_addr = 3'($urandom); req_data = 8'($urandom);
    lat = 0; rdy_seen = 1'b0;
    while (!rsp_valid && lat < 20) begin
      rdy_seen |= req_ready;
      @(posedge clk); #1;
      lat++;
    end
    chk("lat", 32'(lat), 32'(el));
    chk("rsp_data", 32'(rsp_data), 32'(ed));
    chk("rsp_err", 32'(rsp_err), 32'(ee));
    chk("ready_busy", 32'(rdy_seen), 32'd0);
    chk("bus_idle", {28'd0, r_w, add}, {28'd0, 1'b0, IDLE_ADDR});
    chk("wr_pulses", 32'(bus_wr_cnt - wr0), 32'(ewr));
    if (ewr == 1) begin
      chk("wr_addr", 32'(last_wr_addr), 32'(a));
      chk("wr_data", 32'(last_wr_data), 32'(d));
    end
    last_rsp_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_add"},   32'(add),       32'(IDLE_ADDR));
    chk({tag, "_dt"},    32'(dt_out),    32'd0);
    chk({tag, "_rw"},    32'(r_w),       32'd0);
    chk({tag, "_rspv"},  32'(rsp_valid), 32'd0);
    chk({tag, "_rspd"},  32'(rsp_data),  32'd0);
    chk({tag, "_rspe"},  32'(rsp_err),   32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    bit         rw, acc;
    logic [2:0] ra;
    logic [7:0] rd;
    bit         b2b;
    int         rsp_before;

    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    ref_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed sequences.
    do_req(1'b1, 3'd3, 8'hA5, 1'b0);
    do_req(1'b0, 3'd3, 8'h00, 1'b1);
    do_req(1'b1, 3'd1, 8'h11, 1'b1);
    do_req(1'b1, 3'd2, 8'h22, 1'b1);
    do_req(1'b0, 3'd1, 8'h00, 1'b1);
    do_req(1'b0, 3'd2, 8'h00, 1'b1);
    do_req(1'b1, 3'd0, 8'hFF, 1'b1);
    do_req(1'b0, 3'd1, 8'h00, 1'b1);
    do_req(1'b0, 3'd0, 8'h00, 1'b1);
    do_req(1'b0, 3'd0, 8'h00, 1'b1);
    do_req(1'b1, 3'd5, 8'h3C, 1'b1);

    // Randomized traffic with occasional idle gaps.
    b2b = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 3'($urandom_range(0, 7));
      rd = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        b2b = 1'b0;
      end
      do_req(rw, ra, rd, b2b);
      b2b = 1'b1;
    end

    // Reset while the bank is in its write-busy window.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd6; req_data = 8'h77;
    wait_accept(acc);
    chk("rst_accept", 32'(acc), 32'd1);
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rsp_before = rsp_cnt;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ref_reset();
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_rsp", 32'(rsp_cnt), 32'(rsp_before));
    do_req(1'b0, 3'd6, 8'h00, 1'b0);
    do_req(1'b0, 3'd0, 8'h00, 1'b1);
    do_req(1'b1, 3'd4, 8'h96, 1'b1);
    do_req(1'b0, 3'd4, 8'h00, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("rsp_count", 32'(rsp_cnt), 32'(n_rsp_exp));
    chk("busy_violations", 32'(bus_viol), 32'd0);
    chk("addr0_reads", 32'(bus_rd0_cnt), 32'(ref_rd0_total));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
